// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
//   Shared types, constants and helpers for the multi-channel PWM block.
//   Contents:
//     CW          counter/duty width (2**CW must exceed the PWM period)
//     duty_t      one duty or counter value
//     MODE_EDGE   counter runs 0..PERIOD-1 and wraps
//     MODE_CENTER counter runs up to PERIOD and back down to 1
//     sat_step()  adds a button step, wrapping back to a minimum duty
// -----------------------------------------------------------------------------
package pwm_pkg;

   localparam int CW = 8;

   typedef logic [CW-1:0] duty_t;
   typedef logic [CW:0]   duty_ext_t;

   localparam bit MODE_EDGE   = 1'b0;
   localparam bit MODE_CENTER = 1'b1;

   // The sum is formed one bit wider than a duty so it can never overflow;
   // anything beyond the limit falls back to dmin rather than saturating.
   function automatic duty_t sat_step(input duty_t cur, input duty_t step,
                                      input duty_t limit, input duty_t dmin);
      duty_ext_t sum;
      sum = duty_ext_t'(cur) + duty_ext_t'(step);
      if (sum > duty_ext_t'(limit)) begin
         return dmin;
      end
      return sum[CW-1:0];
   endfunction

endpackage

// File: rtl/pwm_multi_ch_if.sv
// -----------------------------------------------------------------------------
// pwm_multi_ch_if
//   Duty-write bus of the multi-channel PWM block.
//   Signals:
//     wr_en    one-cycle write strobe
//     wr_ch    channel index; indices >= NCH are ignored by the PWM block
//     wr_duty  duty value, clamped to the period inside the PWM block
//   Modports: master drives the bus, slave (the PWM block) receives it.
// -----------------------------------------------------------------------------
interface pwm_multi_ch_if
   import pwm_pkg::*;
#(
   parameter int NCH = 4
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic           wr_en;
   logic [CHW-1:0] wr_ch;
   duty_t          wr_duty;

   modport master (output wr_en, output wr_ch, output wr_duty);
   modport slave  (input  wr_en, input  wr_ch, input  wr_duty);

endinterface

// File: rtl/pwm_step_sync.sv
// -----------------------------------------------------------------------------
// pwm_step_sync
//   Per-bit two-flop synchronizer followed by a rising-edge detector for the
//   asynchronous push-button inputs.
//   Ports:
//     CLK      system clock
//     RST      synchronous, active-high reset
//     async_i  raw button levels, one per channel
//     rise_o   one-cycle pulse per synchronized rising edge; a held button
//              gives a single pulse
// -----------------------------------------------------------------------------
module pwm_step_sync #(
   parameter int NCH = 4
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic [NCH-1:0] async_i,
   output logic [NCH-1:0] rise_o
);

   logic [NCH-1:0] sync1_q, sync1_d;
   logic [NCH-1:0] sync2_q, sync2_d;
   logic [NCH-1:0] prev_q,  prev_d;

   // NOTE: every variable assigned here gets a value on every pass, so no latch is inferred.
   always_comb begin
      sync1_d = async_i;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   // Combinational from flops, so a press reaches the duty shadow on the
   // third clock edge after the button rises.
   assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// -----------------------------------------------------------------------------
// pwm_multi_ch
//   NCH-channel PWM generator sharing one period counter. Each channel keeps a
//   shadow duty (written over the bus or stepped by a button) and an active
//   duty that is reloaded from the shadow only on the last cycle of a period,
//   so width changes never glitch a running pulse.
//   Ports:
//     CLK         16 MHz system clock
//     RST         synchronous, active-high reset
//     step_i      asynchronous push buttons, one per channel
//     wr          duty-write bus (pwm_multi_ch_if.slave)
//     pwm_o       registered PWM outputs, one cycle behind the counter
//     period_end  registered one-cycle pulse following the last period cycle
//   Configuration:
//     PWM_CENTER_ALIGN_EN  defined: center-aligned counting, period 2*PERIOD
//                          undefined: edge-aligned counting, period PERIOD
// -----------------------------------------------------------------------------
module pwm_multi_ch
   import pwm_pkg::*;
#(
   parameter int NCH       = 4,
   parameter int PERIOD    = 100,
   parameter int DUTY_INIT = 20,
   parameter int DUTY_MIN  = 20,
   parameter int STEP      = 10
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NCH-1:0]    step_i,
   pwm_multi_ch_if.slave     wr,
   output logic [NCH-1:0]    pwm_o,
   output logic              period_end
);

   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

`ifdef PWM_CENTER_ALIGN_EN
   localparam bit MODE = MODE_CENTER;
`else
   localparam bit MODE = MODE_EDGE;
`endif

   // Counter value on the last cycle of a period (down-count 1 when centered).
   localparam duty_t LAST_CNT = (MODE == MODE_CENTER) ? duty_t'(1) : duty_t'(PERIOD - 1);

   duty_t          cnt_q, cnt_d;
   logic           last_cyc;
   logic           period_end_q, period_end_d;
   logic [NCH-1:0] step_rise;

   pwm_step_sync #(.NCH(NCH)) u_step_sync (
      .CLK     (CLK),
      .RST     (RST),
      .async_i (step_i),
      .rise_o  (step_rise)
   );

   // ---------------------------------------------------------------- counter
`ifdef PWM_CENTER_ALIGN_EN
   logic up_q, up_d;

   always_comb begin
      up_d  = up_q;
      cnt_d = cnt_q;
      if (up_q) begin
         if (cnt_q == duty_t'(PERIOD)) begin
            up_d  = 1'b0;
            cnt_d = cnt_q - duty_t'(1);
         end else begin
            cnt_d = cnt_q + duty_t'(1);
         end
      end else begin
         if (cnt_q == LAST_CNT) begin
            up_d  = 1'b1;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q - duty_t'(1);
         end
      end
   end

   assign last_cyc = !up_q && (cnt_q == LAST_CNT);

   always_ff @(posedge CLK) begin
      if (RST) begin
         up_q <= 1'b1;
      end else begin
         up_q <= up_d;
      end
   end
`else
   always_comb begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + duty_t'(1);
   end

   assign last_cyc = (cnt_q == LAST_CNT);
`endif

   always_comb begin
      period_end_d = last_cyc;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q        <= '0;
         period_end_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         period_end_q <= period_end_d;
      end
   end

   assign period_end = period_end_q;

   // ---------------------------------------------------------- per channel
   for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
      duty_t shadow_q, shadow_d;
      duty_t active_q, active_d;
      logic  pwm_q, pwm_d;
      logic  wr_hit;

      // An out-of-range index matches no channel, so such writes vanish.
      assign wr_hit = wr.wr_en && (wr.wr_ch == CHW'(ch));

      always_comb begin
         shadow_d = shadow_q;
         // A write on this channel takes priority and swallows a same-cycle step.
         if (wr_hit) begin
            shadow_d = (wr.wr_duty > duty_t'(PERIOD)) ? duty_t'(PERIOD) : wr.wr_duty;
         end else if (step_rise[ch]) begin
            shadow_d = sat_step(shadow_q, duty_t'(STEP), duty_t'(PERIOD), duty_t'(DUTY_MIN));
         end
         // Reload reads the pre-write shadow, so a write on the last cycle
         // lands one period later.
         active_d = last_cyc ? shadow_q : active_q;
         pwm_d    = (cnt_q < active_q);
      end

      always_ff @(posedge CLK) begin
         if (RST) begin
            shadow_q <= duty_t'(DUTY_INIT);
            active_q <= duty_t'(DUTY_INIT);
            pwm_q    <= 1'b0;
         end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
         end
      end

      assign pwm_o[ch] = pwm_q;
   end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi_ch
//   Self-checking bench for pwm_multi_ch. A reference model tracks the
//   position inside the PWM period, each channel's pending and governing duty
//   and the sampled button history, and predicts pwm_o and period_end on every
//   clock. Per-period pulse widths are also measured from the outputs and
//   compared with widths derived from the duty. Honours PWM_CENTER_ALIGN_EN.
// -----------------------------------------------------------------------------
module tb_pwm_multi_ch;
   import pwm_pkg::*;

   localparam int NCH       = 4;
   localparam int CHW       = $clog2(NCH);
   localparam int PERIOD    = 100;
   localparam int DUTY_INIT = 20;
   localparam int DUTY_MIN  = 20;
   localparam int STEP      = 10;
`ifdef PWM_CENTER_ALIGN_EN
   localparam int PLEN   = 2 * PERIOD;
   localparam bit CENTER = 1'b1;
`else
   localparam int PLEN   = PERIOD;
   localparam bit CENTER = 1'b0;
`endif

   logic           CLK    = 1'b0;
   logic           RST    = 1'b1;
   logic [NCH-1:0] step_i = '0;
   logic [NCH-1:0] pwm_o;
   logic           period_end;

   pwm_multi_ch_if #(.NCH(NCH)) wr_if ();

   pwm_multi_ch #(
      .NCH       (NCH),
      .PERIOD    (PERIOD),
      .DUTY_INIT (DUTY_INIT),
      .DUTY_MIN  (DUTY_MIN),
      .STEP      (STEP)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .step_i     (step_i),
      .wr         (wr_if.slave),
      .pwm_o      (pwm_o),
      .period_end (period_end)
   );

   always #31 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state
   int             pos;
   int             sh  [NCH];
   int             act [NCH];
   logic [NCH-1:0] h0, h1, h2;

   // Width measurement taken from the outputs
   int hi     [NCH];
   int last_w [NCH];
   int len_cnt;
   int last_len;

   int exp_seq [9] = '{30, 40, 50, 60, 70, 80, 90, 100, 20};

   function automatic int cnt_at(int p);
      if (CENTER && p > PERIOD) return 2 * PERIOD - p;
      return p;
   endfunction

   function automatic int width_of(int d);
      int n = 0;
      for (int p = 0; p < PLEN; p++) if (cnt_at(p) < d) n++;
      return n;
   endfunction

   task automatic check_int(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock: capture the inputs the DUT samples, advance the model, then
   // compare outputs 1 time unit after the edge.
   task automatic tick();
      logic           rst_s, we, exp_pe;
      logic [NCH-1:0] st_s, press, exp_pwm;
      int             wc, wd, c;
      rst_s = RST;
      st_s  = step_i;
      we    = wr_if.wr_en;
      wc    = int'(wr_if.wr_ch);
      wd    = int'(wr_if.wr_duty);
      @(posedge CLK);
      #1;
      cyc++;
      if (rst_s) begin
         pos     = 0;
         h0      = '0;
         h1      = '0;
         h2      = '0;
         exp_pwm = '0;
         exp_pe  = 1'b0;
         for (int ch = 0; ch < NCH; ch++) begin
            sh[ch]  = DUTY_INIT;
            act[ch] = DUTY_INIT;
         end
      end else begin
         c      = cnt_at(pos);
         exp_pe = (pos == PLEN - 1);
         // A button level seen two samples ago after a low sample is a press.
         press  = h1 & ~h2;
         for (int ch = 0; ch < NCH; ch++) begin
            exp_pwm[ch] = (c < act[ch]);
            if (exp_pe) act[ch] = sh[ch];
            if (we && wc == ch) sh[ch] = (wd > PERIOD) ? PERIOD : wd;
            else if (press[ch]) sh[ch] = (sh[ch] + STEP > PERIOD) ? DUTY_MIN : sh[ch] + STEP;
         end
         h2  = h1;
         h1  = h0;
         h0  = st_s;
         pos = (pos + 1) % PLEN;
      end

      checks++;
      assert (pwm_o === exp_pwm) else begin
         errors++;
         $error("FAIL pwm_o cycle %0d: got %b expected %b", cyc, pwm_o, exp_pwm);
      end
      checks++;
      assert (period_end === exp_pe) else begin
         errors++;
         $error("FAIL period_end cycle %0d: got %b expected %b", cyc, period_end, exp_pe);
      end

      if (rst_s) begin
         for (int ch = 0; ch < NCH; ch++) hi[ch] = 0;
         len_cnt = 0;
      end else begin
         for (int ch = 0; ch < NCH; ch++) hi[ch] += int'(pwm_o[ch]);
         len_cnt++;
         if (period_end === 1'b1) begin
            for (int ch = 0; ch < NCH; ch++) begin
               last_w[ch] = hi[ch];
               hi[ch]     = 0;
            end
            last_len = len_cnt;
            len_cnt  = 0;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_pe();
      int n = 0;
      do begin
         tick();
         n++;
      end while (period_end !== 1'b1 && n < 2 * PLEN + 4);
      checks++;
      assert (period_end === 1'b1) else begin
         errors++;
         $error("FAIL period_end_timeout: got %b after %0d cycles expected 1", period_end, n);
      end
   endtask

   task automatic write(input int ch, input int d);
      wr_if.wr_en   = 1'b1;
      wr_if.wr_ch   = CHW'(ch);
      wr_if.wr_duty = duty_t'(d);
      tick();
      wr_if.wr_en   = 1'b0;
   endtask

   task automatic press_btn(input int ch, input int hold);
      step_i[ch] = 1'b1;
      run(hold);
      step_i[ch] = 1'b0;
      run(4);
   endtask

   initial begin
      int prev_w;
      int k;
      wr_if.wr_en   = 1'b0;
      wr_if.wr_ch   = '0;
      wr_if.wr_duty = '0;
      len_cnt       = 0;
      last_len      = 0;
      pos           = 0;
      h0            = '0;
      h1            = '0;
      h2            = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         hi[ch]     = 0;
         last_w[ch] = -1;
         sh[ch]     = DUTY_INIT;
         act[ch]    = DUTY_INIT;
      end

      // Reset values and default duty
      RST = 1'b1;
      run(3);
      RST = 1'b0;
      wait_pe();
      wait_pe();
      check_int("t1_period_len", last_len, PLEN);
      for (int ch = 0; ch < NCH; ch++) check_int("t1_width", last_w[ch], width_of(DUTY_INIT));

      // Nine presses on ch1, each landing in its own period
      prev_w = DUTY_INIT;
      for (int i = 0; i < 9; i++) begin
         press_btn(1, 3);
         wait_pe();
         check_int("t2_old_width", last_w[1], width_of(prev_w));
         wait_pe();
         check_int("t2_new_width", last_w[1], width_of(exp_seq[i]));
         check_int("t2_ch0_width", last_w[0], width_of(DUTY_INIT));
         prev_w = exp_seq[i];
      end

      // Mid-period write, then duty 0, then clamped over-range write
      run(30);
      write(2, 75);
      wait_pe();
      check_int("t3_cur_width", last_w[2], width_of(DUTY_INIT));
      wait_pe();
      check_int("t3_75_width", last_w[2], width_of(75));
      run(10);
      write(2, 0);
      wait_pe();
      wait_pe();
      check_int("t3_zero_width", last_w[2], 0);
      run(10);
      write(2, 250);
      wait_pe();
      wait_pe();
      check_int("t3_clamp_width", last_w[2], width_of(PERIOD));

      // Write and step edge on ch0 in the same cycle, then a long hold
      step_i[0] = 1'b1;
      run(2);
      write(0, 50);
      run(1000);
      step_i[0] = 1'b0;
      run(4);
      wait_pe();
      wait_pe();
      check_int("t4_collision_width", last_w[0], width_of(50));

      // Write on the reload cycle applies one period later
      run(PLEN - 1);
      write(3, 60);
      wait_pe();
      check_int("t4_reload_old", last_w[3], width_of(DUTY_INIT));
      wait_pe();
      check_int("t4_reload_new", last_w[3], width_of(60));

      // Reset in the middle of a period
      write(1, 80);
      wait_pe();
      wait_pe();
      check_int("t5_pre_width", last_w[1], width_of(80));
      run(57);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      wait_pe();
      check_int("t5_period_len", last_len, PLEN);
      for (int ch = 0; ch < NCH; ch++) check_int("t5_width", last_w[ch], width_of(DUTY_INIT));

      // Random writes and button activity against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            wr_if.wr_en   = 1'b1;
            wr_if.wr_ch   = CHW'($urandom_range(0, NCH - 1));
            wr_if.wr_duty = duty_t'($urandom_range(0, 255));
         end else begin
            wr_if.wr_en = 1'b0;
         end
         if ($urandom_range(0, 19) == 0) begin
            k         = int'($urandom_range(0, NCH - 1));
            step_i[k] = ~step_i[k];
         end
         tick();
      end
      wr_if.wr_en = 1'b0;
      step_i      = '0;
      run(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
